// File: rtl/inst_timing.sv
// inst_timing: 6502 opcode latch, interrupt BRK injection and per-opcode instruction length/termination
module inst_timing #(
  parameter int ILLEGAL_LEN = 2,
  parameter bit NMI_EDGE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sync,
  input  logic [5:0] cycle,
  input  logic [7:0] data_in,
  input  logic       irq_n,
  input  logic       nmi_n,
  input  logic       i_flag,
  input  logic       page_cross,
  input  logic       branch_taken,
  output logic       next_sync,
  output logic [7:0] ir,
  output logic [1:0] int_kind,
  output logic       pc_inc,
  output logic       illegal,
  output logic [2:0] tstate
);
  typedef struct packed {
    logic [2:0] len;
    logic       xr;
    logic       br;
    logic       undoc;
  } dec_t;
  function automatic dec_t decode(input logic [7:0] op);
    logic [2:0] a, b;
    logic [1:0] c;
    logic st, rmw;
    dec_t d;
    {a, b, c} = op;
    st = a == 3'd4;
    rmw = ~(a[2] & ~a[1]);
    d = '{len: 3'd2, xr: 1'b0, br: 1'b0, undoc: 1'b0};
    case (c)
      2'b01: case (b)
        3'd0: d.len = 3'd6;
        3'd1: d.len = 3'd3;
        3'd2: d.undoc = st;
        3'd3: d.len = 3'd4;
        3'd4: begin d.len = st ? 3'd6 : 3'd5; d.xr = ~st; end
        3'd5: d.len = 3'd4;
        default: begin d.len = st ? 3'd5 : 3'd4; d.xr = ~st; end
      endcase
      2'b10: case (b)
        3'd0: d.undoc = a != 3'd5;
        3'd1: d.len = rmw ? 3'd5 : 3'd3;
        3'd2: d.len = 3'd2;
        3'd3: d.len = rmw ? 3'd6 : 3'd4;
        3'd4: d.undoc = 1'b1;
        3'd5: d.len = rmw ? 3'd6 : 3'd4;
        3'd6: d.undoc = rmw;
        default: begin
          d.len = a == 3'd5 ? 3'd4 : 3'd7;
          d.xr = a == 3'd5;
          d.undoc = st;
        end
      endcase
      2'b00: case (b)
        3'd0: begin
          d.len = a == 3'd0 ? 3'd7 : a < 3'd4 ? 3'd6 : 3'd2;
          d.undoc = st;
        end
        3'd1: begin d.len = 3'd3; d.undoc = a == 3'd0 || a == 3'd2 || a == 3'd3; end
        3'd2: d.len = a[2] ? 3'd2 : a[0] ? 3'd4 : 3'd3;
        3'd3: begin
          d.len = a == 3'd2 ? 3'd3 : a == 3'd3 ? 3'd5 : 3'd4;
          d.undoc = a == 3'd0;
        end
        3'd4: d.br = 1'b1;
        3'd5: begin d.len = 3'd4; d.undoc = rmw; end
        3'd6: d.len = 3'd2;
        default: begin d.len = 3'd4; d.xr = a == 3'd5; d.undoc = a != 3'd5; end
      endcase
      default: d.undoc = 1'b1;
    endcase
    if (d.undoc) d = '{len: 3'(ILLEGAL_LEN), xr: 1'b0, br: 1'b0, undoc: 1'b1};
    return d;
  endfunction
  dec_t d;
  logic [1:0] ext, ext_eff;
  logic [3:0] last;
  logic nmi_pend, rst_pend, nmi_q, nmi_set, take, fresh;
  assign d = decode(ir);
  assign tstate = cycle[0] ? 3'd0 : cycle[1] ? 3'd1 : cycle[2] ? 3'd2 :
                  cycle[3] ? 3'd3 : cycle[4] ? 3'd4 : cycle[5] ? 3'd5 : 3'd6;
  assign take = rst_pend | nmi_pend | (~irq_n & ~i_flag);
  assign nmi_set = NMI_EDGE ? nmi_q & ~nmi_n : ~nmi_n;
  // Branch page crossing only counts once the taken extension is already registered
  assign ext_eff = d.br ? (ext == 2'd0 ? {1'b0, tstate == 3'd1 && branch_taken}
                                       : (ext[1] | page_cross) ? 2'd2 : 2'd1)
                 : d.xr ? ext | {1'b0, page_cross} : 2'd0;
  assign last = {1'b0, d.len} + {2'b0, ext_eff} - 4'd1;
  assign next_sync = reset | (~sync & (cycle == 6'd0 || {1'b0, tstate} == last));
  assign pc_inc = ~reset & sync & ~take;
  assign illegal = fresh & d.undoc;
  always_ff @(posedge clk) begin
    if (reset) begin
      ir <= 8'h00;
      int_kind <= 2'b11;
      fresh <= 1'b0;
      ext <= 2'd0;
      nmi_pend <= 1'b0;
      rst_pend <= 1'b1;
      nmi_q <= 1'b1;
    end else begin
      nmi_q <= nmi_n;
      nmi_pend <= nmi_set | (nmi_pend & ~(sync & ~rst_pend));
      fresh <= sync & ~take;
      ext <= sync ? 2'd0 : ext_eff;
      if (sync) begin
        rst_pend <= 1'b0;
        ir <= take ? 8'h00 : data_in;
        int_kind <= rst_pend ? 2'b11 : nmi_pend ? 2'b10 : take ? 2'b01 : 2'b00;
      end
    end
  end
endmodule

// File: tb/tb_inst_timing.sv
// tb_inst_timing: plays the sequencer against inst_timing and checks lengths, decode and interrupts
module tb_inst_timing;
  logic clk = 1'b0, reset, sync, irq_n, nmi_n, i_flag, page_cross, branch_taken;
  logic [5:0] cycle;
  logic [7:0] data_in, ir;
  logic [1:0] int_kind;
  logic [2:0] tstate;
  logic next_sync, pc_inc, illegal;
  int tests = 0, fails = 0;
  typedef struct {
    int op, pc_t, taken, nmi_t, irq, ifl, len, eir, ekind, epc, eill;
  } vec_t;
  vec_t vecs[$];
  inst_timing dut (
    .clk(clk), .reset(reset), .sync(sync), .cycle(cycle), .data_in(data_in),
    .irq_n(irq_n), .nmi_n(nmi_n), .i_flag(i_flag), .page_cross(page_cross),
    .branch_taken(branch_taken), .next_sync(next_sync), .ir(ir), .int_kind(int_kind),
    .pc_inc(pc_inc), .illegal(illegal), .tstate(tstate)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(int op, int pc_t, int taken, int nmi_t, int irq, int ifl,
                              int len, int eir, int ekind, int epc, int eill);
    vec_t v;
    v = '{op, pc_t, taken, nmi_t, irq, ifl, len, eir, ekind, epc, eill};
    return v;
  endfunction
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic run(input vec_t v, input string nm);
    int len = 0;
    for (int t = 0; t < 7 && len == 0; t++) begin
      sync = t == 0;
      cycle = t == 6 ? 6'b0 : 6'(1 << t);
      data_in = t == 0 ? 8'(v.op) : 8'hFF;
      page_cross = t == v.pc_t;
      branch_taken = t == 1 && v.taken != 0;
      nmi_n = t < v.nmi_t;
      irq_n = v.irq[0];
      i_flag = v.ifl[0];
      @(negedge clk);
      if (t == 0) chk({nm, " pc_inc"}, int'(pc_inc), v.epc);
      if (t == 1) begin
        chk({nm, " ir"}, int'(ir), v.eir);
        chk({nm, " int_kind"}, int'(int_kind), v.ekind);
        chk({nm, " illegal T1"}, int'(illegal), v.eill);
      end
      if (t == 2) chk({nm, " illegal T2"}, int'(illegal), 0);
      if (next_sync) len = t + 1;
      @(posedge clk);
      #1;
    end
    chk({nm, " length"}, len, v.len);
  endtask
  initial begin
    int cyc_in[9] = '{1, 2, 4, 8, 16, 32, 0, 10, 48};
    int cyc_ts[9] = '{0, 1, 2, 3, 4, 5, 6, 1, 4};
    reset = 1'b1; sync = 1'b1; cycle = 6'd1; data_in = 8'hEA; irq_n = 1'b1; nmi_n = 1'b1;
    i_flag = 1'b1; page_cross = 1'b0; branch_taken = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset next_sync", int'(next_sync), 1);
    chk("reset pc_inc", int'(pc_inc), 0);
    chk("reset ir", int'(ir), 0);
    chk("reset int_kind", int'(int_kind), 3);
    chk("reset illegal", int'(illegal), 0);
    for (int i = 0; i < 9; i++) begin
      cycle = 6'(cyc_in[i]);
      #1;
      chk($sformatf("tstate cycle=%b", cycle), int'(tstate), cyc_ts[i]);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    vecs.push_back(mk(8'hEA, 7, 0, 7, 1, 1, 7, 8'h00, 3, 0, 0));
    vecs.push_back(mk(8'hA9, 7, 0, 7, 1, 1, 2, 8'hA9, 0, 1, 0));
    vecs.push_back(mk(8'hBD, 2, 0, 7, 1, 1, 5, 8'hBD, 0, 1, 0));
    vecs.push_back(mk(8'hBD, 7, 0, 7, 1, 1, 4, 8'hBD, 0, 1, 0));
    vecs.push_back(mk(8'hD0, 7, 0, 7, 1, 1, 2, 8'hD0, 0, 1, 0));
    vecs.push_back(mk(8'hD0, 7, 1, 7, 1, 1, 3, 8'hD0, 0, 1, 0));
    vecs.push_back(mk(8'hD0, 2, 1, 7, 1, 1, 4, 8'hD0, 0, 1, 0));
    vecs.push_back(mk(8'h02, 7, 0, 7, 1, 1, 2, 8'h02, 0, 1, 1));
    vecs.push_back(mk(8'h03, 7, 0, 7, 1, 1, 2, 8'h03, 0, 1, 1));
    vecs.push_back(mk(8'h8D, 7, 0, 7, 1, 1, 4, 8'h8D, 0, 1, 0));
    vecs.push_back(mk(8'h9D, 2, 0, 7, 1, 1, 5, 8'h9D, 0, 1, 0));
    vecs.push_back(mk(8'h91, 7, 0, 7, 1, 1, 6, 8'h91, 0, 1, 0));
    vecs.push_back(mk(8'hB1, 3, 0, 7, 1, 1, 6, 8'hB1, 0, 1, 0));
    vecs.push_back(mk(8'hFE, 7, 0, 7, 1, 1, 7, 8'hFE, 0, 1, 0));
    vecs.push_back(mk(8'h6C, 7, 0, 7, 1, 1, 5, 8'h6C, 0, 1, 0));
    vecs.push_back(mk(8'h20, 7, 0, 7, 1, 1, 6, 8'h20, 0, 1, 0));
    vecs.push_back(mk(8'h60, 7, 0, 7, 1, 1, 6, 8'h60, 0, 1, 0));
    vecs.push_back(mk(8'h48, 7, 0, 7, 1, 1, 3, 8'h48, 0, 1, 0));
    vecs.push_back(mk(8'h68, 7, 0, 7, 1, 1, 4, 8'h68, 0, 1, 0));
    vecs.push_back(mk(8'h28, 7, 0, 7, 1, 1, 4, 8'h28, 0, 1, 0));
    vecs.push_back(mk(8'h0E, 7, 0, 7, 1, 1, 6, 8'h0E, 0, 1, 0));
    vecs.push_back(mk(8'h4C, 7, 0, 7, 1, 1, 3, 8'h4C, 0, 1, 0));
    vecs.push_back(mk(8'hA1, 7, 0, 7, 1, 1, 6, 8'hA1, 0, 1, 0));
    vecs.push_back(mk(8'hB6, 7, 0, 7, 1, 1, 4, 8'hB6, 0, 1, 0));
    vecs.push_back(mk(8'h96, 7, 0, 7, 1, 1, 4, 8'h96, 0, 1, 0));
    vecs.push_back(mk(8'hBE, 2, 0, 7, 1, 1, 5, 8'hBE, 0, 1, 0));
    vecs.push_back(mk(8'h0A, 7, 0, 7, 1, 1, 2, 8'h0A, 0, 1, 0));
    foreach (vecs[i]) run(vecs[i], $sformatf("vec%0d op=%02h", i, vecs[i].op));
    // NMI falls mid-instruction while IRQ is also requested on the following fetches
    run(mk(8'h8D, 7, 0, 2, 1, 1, 4, 8'h8D, 0, 1, 0), "nmi arm");
    run(mk(8'hA9, 7, 0, 7, 0, 0, 7, 8'h00, 2, 0, 0), "nmi brk");
    run(mk(8'hA9, 7, 0, 7, 0, 0, 7, 8'h00, 1, 0, 0), "irq brk");
    run(mk(8'hA9, 7, 0, 7, 0, 1, 2, 8'hA9, 0, 1, 0), "irq masked");
    sync = 1'b1; cycle = 6'd1; data_in = 8'h00; irq_n = 1'b1; nmi_n = 1'b1; i_flag = 1'b1;
    page_cross = 1'b0; branch_taken = 1'b0;
    @(posedge clk);
    #1;
    sync = 1'b0; cycle = 6'd2;
    chk("abort ir", int'(ir), 0);
    chk("abort int_kind", int'(int_kind), 0);
    @(posedge clk);
    #1;
    cycle = 6'd4;
    @(posedge clk);
    #1;
    cycle = 6'd8;
    #1;
    chk("abort T3 next_sync", int'(next_sync), 0);
    reset = 1'b1; sync = 1'b1;
    #1;
    chk("abort next_sync", int'(next_sync), 1);
    chk("abort pc_inc", int'(pc_inc), 0);
    @(posedge clk);
    #1;
    chk("abort reset ir", int'(ir), 0);
    chk("abort reset int_kind", int'(int_kind), 3);
    reset = 1'b0;
    run(mk(8'hA9, 7, 0, 7, 1, 1, 7, 8'h00, 3, 0, 0), "post-abort reset brk");
    run(mk(8'hA9, 7, 0, 7, 1, 1, 2, 8'hA9, 0, 1, 0), "post-abort fetch");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
